// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_ndig(input int w, input int b);
    return w / b;
  endfunction

  // A single-digit configuration still carries a 1-bit counter that stays at zero.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  function automatic bit width_ok(input int w, input int b);
    return (b >= 1) && (b <= w) && ((w % b) == 0);
  endfunction

endpackage

// File: rtl/digit_adder_slice.sv
// Combinational B-bit adder slice, with the carry into its top bit exposed
// so that signed overflow can be formed on the most significant digit.
module digit_adder_slice #(
  parameter int B = 8
) (
  input  logic [B-1:0] x,
  input  logic [B-1:0] y,
  input  logic         ci,
  output logic [B-1:0] s,
  output logic         co,
  output logic         c_msb_in,
  output logic         prop
);

  logic [B:0] total;

  assign total    = {1'b0, x} + {1'b0, y} + {{B{1'b0}}, ci};
  assign s        = total[B-1:0];
  assign co       = total[B];
  // The sum bit is x ^ y ^ carry-in, so the carry into the top bit falls out of it.
  assign c_msb_in = x[B-1] ^ y[B-1] ^ total[B-1];
  assign prop     = &(x ^ y);

endmodule

// File: rtl/digit_serial_adder.sv
// W-bit adder/subtractor that walks one B-bit digit per clock through a single
// slice, LSB digit first, with valid/ready handshakes on both sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         p
);

  localparam int NDIG = calc_ndig(W, B);
  localparam int CW   = calc_cnt_w(NDIG);

  if (!width_ok(W, B)) begin : g_bad_width
    $error("digit_serial_adder: W must be a multiple of B and 1 <= B <= W");
  end

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NDIG-1:0][B-1:0]     a_q, a_d;
  logic [NDIG-1:0][B-1:0]     b_q, b_d;
  logic [NDIG-1:0][B-1:0]     sum_q, sum_d;
  logic                       carry_q, carry_d;
  logic                       pacc_q, pacc_d;
  logic                       out_valid_q, out_valid_d;
  logic                       cout_q, cout_d;
  logic                       ovf_q, ovf_d;
  logic                       p_q, p_d;

  logic [B-1:0] slice_s;
  logic         slice_co;
  logic         slice_c_msb;
  logic         slice_prop;
  logic         last_digit;
  logic         accept;

  digit_adder_slice #(.B(B)) u_slice (
    .x        (a_q[cnt_q]),
    .y        (b_q[cnt_q]),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_c_msb),
    .prop     (slice_prop)
  );

  assign last_digit = (cnt_q == CW'(NDIG - 1));
  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    pacc_d      = pacc_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    p_d         = p_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        sum_d[cnt_q] = slice_s;
        carry_d      = slice_co;
        pacc_d       = pacc_q & slice_prop;
        if (last_digit) begin
          cout_d      = slice_co;
          ovf_d       = slice_c_msb ^ slice_co;
          p_d         = pacc_q & slice_prop;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is a + ~b + ~cin, so the inversion happens once at load time.
    if (accept) begin
      a_d         = a;
      b_d         = sub ? ~b : b;
      carry_d     = sub ? ~cin : cin;
      sum_d       = '0;
      pacc_d      = 1'b1;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      pacc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      p_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      pacc_q      <= pacc_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      p_q         <= p_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign p         = p_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: a W=8/B=4 instance and a W=B=8 instance,
// checked each cycle against an arithmetic model plus directed cases.
module tb_digit_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       p;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv[2], ir[2], cin_s[2], sub_s[2], ov[2], ordy[2];
  logic       co_s[2], ovf_s[2], p_s[2];
  logic [7:0] a_s[2], b_s[2], sum_s[2];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic        pend[2];
  res_t        er[2];
  int unsigned eacc[2];

  always #5 clk = ~clk;

  digit_serial_adder #(.W(8), .B(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum_s[0]),
    .cout(co_s[0]), .ovf(ovf_s[0]), .p(p_s[0])
  );

  digit_serial_adder #(.W(8), .B(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum_s[1]),
    .cout(co_s[1]), .ovf(ovf_s[1]), .p(p_s[1])
  );

  function automatic int ndig_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Plain integer arithmetic: unsigned result for sum/cout, signed range for ovf.
  function automatic res_t model(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic sv);
    res_t r;
    int   ua, ub, sa, sb, full, sres;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (!sv) begin
      full   = ua + ub + int'(cv);
      sres   = sa + sb + int'(cv);
      r.cout = (full > 255);
    end else begin
      full   = ua - ub - int'(cv);
      sres   = sa - sb - int'(cv);
      r.cout = (full >= 0);
    end
    r.sum = full[7:0];
    r.ovf = (sres > 127) || (sres < -128);
    r.p   = &(av ^ (sv ? ~bv : bv));
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  task automatic sb_step(input int k);
    logic exp_ov, exp_ir;
    exp_ov = pend[k] && (cyc >= eacc[k] + ndig_of(k));
    exp_ir = !pend[k] || (exp_ov && ordy[k]);
    chk("sb_out_valid", k, 32'(ov[k]), 32'(exp_ov));
    chk("sb_in_ready", k, 32'(ir[k]), 32'(exp_ir));
    if (exp_ov) begin
      chk("sb_sum", k, 32'(sum_s[k]), 32'(er[k].sum));
      chk("sb_cout", k, 32'(co_s[k]), 32'(er[k].cout));
      chk("sb_ovf", k, 32'(ovf_s[k]), 32'(er[k].ovf));
      chk("sb_p", k, 32'(p_s[k]), 32'(er[k].p));
      if (ordy[k]) pend[k] = 1'b0;
    end
    if (iv[k] && exp_ir) begin
      pend[k] = 1'b1;
      er[k]   = model(a_s[k], b_s[k], cin_s[k], sub_s[k]);
      eacc[k] = cyc + 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
      end else begin
        sb_step(0);
        sb_step(1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  function automatic logic [7:0] rnd8();
    case ($urandom % 6)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv, input logic [7:0] es,
                        input logic ec, input logic eo, input logic ep);
    int lat;
    logic found;
    @(posedge clk); #1;
    iv[k] = 1'b1; a_s[k] = av; b_s[k] = bv; cin_s[k] = cv; sub_s[k] = sv;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[k]) begin
        found = 1'b1;
        lat = i;
        break;
      end
    end
    chk("op_done_in_time", k, 32'(found), 32'd1);
    chk("op_latency", k, 32'(lat), 32'(ndig_of(k)));
    chk("op_sum", k, 32'(sum_s[k]), 32'(es));
    chk("op_cout", k, 32'(co_s[k]), 32'(ec));
    chk("op_ovf", k, 32'(ovf_s[k]), 32'(eo));
    chk("op_p", k, 32'(p_s[k]), 32'(ep));
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0;
      sub_s[k] = 1'b0; ordy[k] = 1'b0;
    end

    chk("model_add", 0, 32'(model(8'd23, 8'd45, 1'b1, 1'b0)), 32'({8'd69, 3'b000}));
    chk("model_wrap", 0, 32'(model(8'h00, 8'hFF, 1'b1, 1'b0)), 32'({8'd0, 3'b101}));
    chk("model_ovf", 0, 32'(model(8'h80, 8'h80, 1'b0, 1'b0)), 32'({8'd0, 3'b110}));
    chk("model_sub", 0, 32'(model(8'd34, 8'd23, 1'b0, 1'b1)), 32'({8'd11, 3'b100}));
    chk("model_sub_neg", 0, 32'(model(8'd23, 8'd34, 1'b0, 1'b1)), 32'({8'hF5, 3'b000}));

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, 32'(ir[k]), 32'd1);
      chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_sum", k, 32'(sum_s[k]), 32'd0);
      chk("rst_cout", k, 32'(co_s[k]), 32'd0);
      chk("rst_ovf", k, 32'(ovf_s[k]), 32'd0);
      chk("rst_p", k, 32'(p_s[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      run_op(k, 8'd23, 8'd45, 1'b1, 1'b0, 8'd69, 1'b0, 1'b0, 1'b0);
      run_op(k, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      run_op(k, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      run_op(k, 8'd34, 8'd23, 1'b0, 1'b1, 8'd11, 1'b1, 1'b0, 1'b0);
      run_op(k, 8'd23, 8'd34, 1'b0, 1'b1, 8'hF5, 1'b0, 1'b0, 1'b0);
    end

    // Back-pressure then a back-to-back accept on the digit-serial instance.
    @(posedge clk); #1;
    iv[0] = 1'b1; a_s[0] = 8'h5A; b_s[0] = 8'h33; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_done_in_time", 0, 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum_hold", 0, 32'(sum_s[0]), 32'h8D);
      chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
      chk("bp_out_valid", 0, 32'(ov[0]), 32'd1);
    end
    ordy[0] = 1'b1;
    iv[0] = 1'b1; a_s[0] = 8'h7F; b_s[0] = 8'h01; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    #1;
    chk("b2b_in_ready", 0, 32'(ir[0]), 32'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("b2b_valid_fall", 0, 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_valid_mid", 0, 32'(ov[0]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_valid_rise", 0, 32'(ov[0]), 32'd1);
    chk("b2b_sum", 0, 32'(sum_s[0]), 32'h80);
    chk("b2b_ovf", 0, 32'(ovf_s[0]), 32'd1);
    chk("b2b_cout", 0, 32'(co_s[0]), 32'd0);

    // Reset after the first digit has been written.
    @(posedge clk); #1;
    iv[0] = 1'b1; a_s[0] = 8'h12; b_s[0] = 8'h34; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_partial_sum", 0, 32'(sum_s[0]), 32'h06);
    chk("mid_not_valid", 0, 32'(ov[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("mid_rst_sum", 0, 32'(sum_s[0]), 32'd0);
    chk("mid_rst_in_ready", 0, 32'(ir[0]), 32'd1);
    chk("mid_rst_cout", 0, 32'(co_s[0]), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        iv[k]    = 1'($urandom_range(0, 1));
        a_s[k]   = rnd8();
        b_s[k]   = rnd8();
        cin_s[k] = 1'($urandom_range(0, 1));
        sub_s[k] = 1'($urandom_range(0, 1));
        ordy[k]  = (($urandom % 4) != 0);
      end
    end

    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
